// File: rtl/m_port_ultra_hull_merger.sv
// m_port_ultra_hull_merger
// Compacts the four partial convex hulls from the quickhull processor array
// into one contiguous point cloud, one point per clock, hull 1 first.
// Optional build macro: PORT_ULTRA_MERGER_DEDUP_EN drops a point that is
// bit-identical to the most recently written point.
module m_port_ultra_hull_merger (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mergeEnable,
    input  logic [4095:0]  convexHull1,
    input  logic [4095:0]  convexHull2,
    input  logic [4095:0]  convexHull3,
    input  logic [4095:0]  convexHull4,
    input  logic [8:0]     convexHullSize1,
    input  logic [8:0]     convexHullSize2,
    input  logic [8:0]     convexHullSize3,
    input  logic [8:0]     convexHullSize4,
    input  logic           processorDone1,
    input  logic           processorDone2,
    input  logic           processorDone3,
    input  logic           processorDone4,
    output logic [16383:0] mergedCloud,
    output logic [10:0]    mergedSize,
    output logic           mergeDone
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COPY, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     hull_q, hull_d;       // 0..3 selects hull 1..4
    logic [8:0]     idx_q, idx_d;         // read index within selected hull, 0..256
    logic [3:0]     flags_q, flags_d;     // sticky processor-done flags
    logic [10:0]    size_q, size_d;
    logic [16383:0] cloud_q, cloud_d;
    logic           done_q, done_d;

    logic [4095:0]  sel_hull;
    logic [8:0]     sel_size;
    logic [8:0]     eff_size;
    logic [15:0]    point;
    logic           skip;
    logic [3:0]     done_vec;

    assign done_vec = {processorDone4, processorDone3, processorDone2, processorDone1};

    // Select the hull currently being drained; data is read straight from the inputs.
    always_comb begin
        sel_hull = convexHull1;
        sel_size = convexHullSize1;
        case (hull_q)
            2'd0: begin sel_hull = convexHull1; sel_size = convexHullSize1; end
            2'd1: begin sel_hull = convexHull2; sel_size = convexHullSize2; end
            2'd2: begin sel_hull = convexHull3; sel_size = convexHullSize3; end
            default: begin sel_hull = convexHull4; sel_size = convexHullSize4; end
        endcase
    end

    // Sizes above 256 are out-of-range reports; clamp to a full hull.
    assign eff_size = (sel_size > 9'd256) ? 9'd256 : sel_size;
    // Index is below eff_size (<= 256) whenever the point is used, so 8 bits suffice.
    assign point    = sel_hull[{idx_q[7:0], 4'b0000} +: 16];

`ifdef PORT_ULTRA_MERGER_DEDUP_EN
    logic [10:0] prev_slot;
    assign prev_slot = size_q - 11'd1;
    // The most recently written point is always the top of the cloud.
    assign skip = (size_q != 11'd0) && (point == cloud_q[{prev_slot[9:0], 4'b0000} +: 16]);
`else
    assign skip = 1'b0;
`endif

    // Next-state and datapath update for the merge FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        hull_d  = hull_q;
        idx_d   = idx_q;
        flags_d = flags_q;
        size_d  = size_q;
        cloud_d = cloud_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (mergeEnable) begin
                    state_d = S_WAIT;
                    flags_d = '0;
                    size_d  = '0;
                    cloud_d = '0;
                    done_d  = 1'b0;
                end
            end

            S_WAIT: begin
                flags_d = flags_q | done_vec;
                if (!mergeEnable) begin
                    state_d = S_IDLE;
                    size_d  = '0;
                    cloud_d = '0;
                end else if (&flags_d) begin
                    state_d = S_COPY;
                    hull_d  = 2'd0;
                    idx_d   = 9'd0;
                end
            end

            S_COPY: begin
                if (!mergeEnable) begin
                    state_d = S_IDLE;
                    size_d  = '0;
                    cloud_d = '0;
                end else if (idx_q < eff_size) begin
                    idx_d = idx_q + 9'd1;
                    if (!skip) begin
                        cloud_d[{size_q[9:0], 4'b0000} +: 16] = point;
                        size_d = size_q + 11'd1;
                    end
                end else if (hull_q == 2'd3) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    hull_d = hull_q + 2'd1;
                    idx_d  = 9'd0;
                end
            end

            default: begin  // S_DONE
                if (!mergeEnable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q <= S_IDLE;
            hull_q  <= 2'd0;
            idx_q   <= 9'd0;
            flags_q <= 4'd0;
            size_q  <= 11'd0;
            // NOTE: the cloud is a register array that must read as zero after reset, so it is reset.
            cloud_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hull_q  <= hull_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
            size_q  <= size_d;
            cloud_q <= cloud_d;
            done_q  <= done_d;
        end
    end

    assign mergedCloud = cloud_q;
    assign mergedSize  = size_q;
    assign mergeDone   = done_q;

endmodule

// File: doc/m_port_ultra_hull_merger.md
# m_port_ultra_hull_merger

Collects the four partial convex hulls produced by the four-unit quickhull processor array and compacts them, one point per clock, into a single contiguous point cloud for the final hull pass. It sits directly downstream of the processor array. It waits until all four processors report done, then concatenates hulls 1→4 in order, dropping the unused tail slots of each hull.

## Interface
Parameters:
- none (geometry fixed: 16-bit points, 256 points per hull, 4 hulls)

Ports:
- `clk` in 1: system clock; one clock domain only.
- `reset_n` in 1: reset is synchronous and active-low.
- `mergeEnable` in 1: level request. High starts a merge; low aborts a merge or releases the block.
- `convexHull1`..`convexHull4` in 4096 each: hull points. Point i occupies bits [16i+15:16i].
- `convexHullSize1`..`convexHullSize4` in 9 each: valid point count per hull, 0..256.
- `processorDone1`..`processorDone4` in 1 each: processor completion flags, level or pulse.
- `mergedCloud` out 16384: compacted points. Point k occupies bits [16k+15:16k].
- `mergedSize` out 11: number of valid points in `mergedCloud`, 0..1024.
- `mergeDone` out 1: high while the result is valid.

## Operation
- FSM states: IDLE, WAIT, COPY, DONE.
- IDLE:
  - Outputs held.
  - `mergeEnable`=1 → WAIT. The transition edge clears `mergedCloud`, `mergedSize`, the four sticky done flags, and `mergeDone`.
- WAIT:
  - Each `processorDoneN` sampled high sets sticky flag N.
  - When all four flags are set, counting flags set on this same edge, → COPY. Hull select = 1, read index = 0.
- COPY, one action per cycle:
  - If read index < effective size of the selected hull: write point[index] to `mergedCloud` slot `mergedSize`, increment `mergedSize` and the index.
  - Otherwise, with the index at the effective size, spend one cycle advancing: next hull, index = 0.
  - Advancing past hull 4 → DONE.
- Effective size = min(`convexHullSizeN`, 256). Values 257..511 are treated as 256.
- DONE:
  - `mergeDone`=1. Outputs held stable.
  - `mergeEnable`=0 → IDLE with `mergeDone`=0. `mergedCloud` and `mergedSize` are retained until the next start.
- Abort: `mergeEnable`=0 in WAIT or COPY → IDLE on the next edge. `mergedSize` is cleared to 0 and `mergedCloud` to all zeros.
- Input stability: hull data and sizes are read directly from the inputs during COPY, with no latching. Upstream holds them stable from done until `mergeDone` falls.
- Slots at or above `mergedSize` read as zero.
- Arithmetic: `mergedSize` is 11-bit and never exceeds 1024, so it cannot wrap.

## Timing
- Reset, synchronous with `reset_n`=0 at a rising edge:
  - State = IDLE.
  - `mergedCloud`=0, `mergedSize`=0, `mergeDone`=0, sticky flags = 0.
- Reset mid-operation overrides everything and behaves as above.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: let S = sum of effective sizes and E = the edge that enters COPY.
  - COPY lasts exactly S+4 cycles.
  - `mergeDone` is high after edge E+S+4.
  - `mergedSize` increments by at most 1 per edge.
- Minimum end-to-end latency, with all done flags already high: start edge into WAIT, one edge into COPY, then S+4 cycles.
- Simultaneous events:
  - `mergeEnable` falling on the same edge WAIT would enter COPY → abort wins.
  - `mergeEnable` falling on the same edge COPY would finish → abort wins.

## Configuration
- Macro: `PORT_ULTRA_MERGER_DEDUP_EN`.
- Defined:
  - In COPY, a point bit-identical to the most recently written point is skipped. This applies across hull boundaries.
  - A skipped point is not written, and `mergedSize` is not incremented.
  - It still costs one cycle, so latency remains S+4.
  - The first point of a merge is always written.
- Undefined: every valid point is written; `mergedSize` = S.

## Test plan
- **Basic merge:** sizes 3,2,0,1; hull1 = {0x0101,0x0202,0x0303}, hull2 = {0x0404,0x0505}, hull4 = {0x0606}; all done high; `mergeEnable`=1 → `mergeDone` high 10 cycles after COPY entry; `mergedSize`=6; slots 0..5 = 0x0101..0x0606; slot 6 = 0.
- **Staggered done:** pulse done4, done1, done3, done2 one cycle each, 5 cycles apart → COPY entered only after the done2 edge; result is correct.
- **Full and clamped:** all sizes 256, then all sizes 300 (clamp) → `mergedSize`=1024; COPY lasts 1028 cycles; slot k = hull(k/256+1) point k%256.
- **Abort:** drop `mergeEnable` after 5 COPY cycles → IDLE next edge; `mergedSize`=0; `mergeDone` never asserted.
- **Reset mid-COPY:** `reset_n`=0 for one edge → all outputs 0; state IDLE; a fresh start then merges correctly.
- **Dedup** (macro defined): sizes 2,2,0,0; hull1 = {0x1111,0x2222}, hull2 = {0x2222,0x3333} → `mergedSize`=3; slots = 0x1111,0x2222,0x3333; latency 8 cycles. With the macro undefined → `mergedSize`=4.
